multi_sig_control: RTL and testbench

MULTI_SIG_CONTROL -- requirements
Module: multi_sig_control

---
 rtl/sig_pkg.sv | 22 ++
 rtl/phase_timer.sv | 28 ++
 rtl/multi_sig_control.sv | 207 ++++++++++++++++++++
 tb/tb_multi_sig_control.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/sig_pkg.sv
// Shared definitions for the multi-approach signal controller:
// light encodings, controller state enum and default phase timings.
package sig_pkg;

   localparam logic [1:0] LT_RED    = 2'd0;
   localparam logic [1:0] LT_YELLOW = 2'd1;
   localparam logic [1:0] LT_GREEN  = 2'd2;

   typedef enum logic [1:0] {
      ST_GREEN  = 2'd0,
      ST_YELLOW = 2'd1,
      ST_ALLRED = 2'd2,
      ST_PED    = 2'd3
   } state_t;

   localparam int DEF_MIN_GREEN   = 4;
   localparam int DEF_MAX_GREEN   = 10;
   localparam int DEF_YELLOW_TIME = 3;
   localparam int DEF_ALLRED_TIME = 2;
   localparam int DEF_WALK_TIME   = 6;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for phase timing. done is high while the count is zero.
module phase_timer
   import sig_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             en,
   output logic [CNT_W-1:0] cnt,
   output logic             done
);

   // reload has priority over counting
   always_ff @(posedge clock or negedge clear) begin
      if (!clear)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en)
         cnt <= cnt - 1'b1;
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/multi_sig_control.sv
// Multi-approach traffic signal controller. Approach 0 is the main road.
// Optional pedestrian walk phase enabled by defining PED_SIG_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_GREEN  | active approach GREEN, all others RED
// ST_YELLOW | active approach YELLOW, next approach already latched
// ST_ALLRED | all RED clearance
// ST_PED    | all RED, walk asserted (PED_SIG_EN only)
//
// In GREEN the timer is loaded with 0 and counts down through wrap, so
// (0 - cnt) is the number of green cycles already elapsed; it stops once
// both green thresholds are reached so long greens never wrap back.
module multi_sig_control
   import sig_pkg::*;
#(
   parameter int NUM_APPR    = 4,
   parameter int MIN_GREEN   = DEF_MIN_GREEN,
   parameter int MAX_GREEN   = DEF_MAX_GREEN,
   parameter int YELLOW_TIME = DEF_YELLOW_TIME,
   parameter int ALLRED_TIME = DEF_ALLRED_TIME,
   parameter int CNT_W       = 8
`ifdef PED_SIG_EN
   ,
   parameter int WALK_TIME   = DEF_WALK_TIME
`endif
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic [NUM_APPR-1:0]   car_req,
`ifdef PED_SIG_EN
   input  logic                  ped_req,
   output logic                  walk,
`endif
   output logic [2*NUM_APPR-1:0] sig,
   output logic [2:0]            active
);

   localparam int SAT_GREEN = ((MIN_GREEN > MAX_GREEN) ? MIN_GREEN : MAX_GREEN) - 1;
   localparam logic [2*NUM_APPR-1:0] SIG_RST = (2*NUM_APPR)'(LT_GREEN);

   state_t                state, state_nxt;
   logic [2:0]            active_nxt, next_appr, next_appr_nxt, rr_pick;
   logic [NUM_APPR-1:0]   act_mask;
   logic                  own_req, other_req, rr_found;
   logic                  tmr_load, tmr_en, tmr_done;
   logic [CNT_W-1:0]      tmr_val, tmr_cnt, g_elapsed;
   logic                  min_ok, max_hit, green_exit;
   logic [2*NUM_APPR-1:0] sig_nxt;
`ifdef PED_SIG_EN
   logic                  ped_pend, ped_clr;
`endif

   phase_timer #(.CNT_W(CNT_W)) u_timer (
      .clock    (clock),
      .clear    (clear),
      .load     (tmr_load),
      .load_val (tmr_val),
      .en       (tmr_en),
      .cnt      (tmr_cnt),
      .done     (tmr_done)
   );

   // one-hot mask of the approach holding right of way
   always_comb begin
      act_mask = '0;
      for (int i = 0; i < NUM_APPR; i++)
         act_mask[i] = (active == 3'(i));
   end

   assign own_req   = |(car_req & act_mask);
   assign other_req = |(car_req & ~act_mask);

   // round-robin pick: indices above active first, then wrap from 0; main road if none
   always_comb begin
      rr_pick  = 3'd0;
      rr_found = 1'b0;
      for (int j = 0; j < NUM_APPR; j++) begin
         if (!rr_found && car_req[j] && (3'(j) > active)) begin
            rr_pick  = 3'(j);
            rr_found = 1'b1;
         end
      end
      for (int j = 0; j < NUM_APPR; j++) begin
         if (!rr_found && car_req[j] && (3'(j) < active)) begin
            rr_pick  = 3'(j);
            rr_found = 1'b1;
         end
      end
   end

   assign g_elapsed  = CNT_W'(0) - tmr_cnt;
   assign min_ok     = (g_elapsed >= CNT_W'(MIN_GREEN - 1));
   assign max_hit    = (g_elapsed >= CNT_W'(MAX_GREEN - 1));
   assign green_exit = min_ok && ((active == 3'd0) ? other_req
                                                    : (!own_req || (max_hit && other_req)));

   // next-state, timer reload and next-approach latch decisions
   always_comb begin
      state_nxt     = state;
      active_nxt    = active;
      next_appr_nxt = next_appr;
      tmr_load      = 1'b0;
      tmr_val       = '0;
      tmr_en        = 1'b1;
`ifdef PED_SIG_EN
      ped_clr       = 1'b0;
`endif
      case (state)
         ST_GREEN: begin
            tmr_en = (g_elapsed < CNT_W'(SAT_GREEN));
            if (green_exit) begin
               state_nxt     = ST_YELLOW;
               next_appr_nxt = rr_pick;
               tmr_load      = 1'b1;
               tmr_val       = CNT_W'(YELLOW_TIME - 1);
            end
         end
         ST_YELLOW: begin
            if (tmr_done) begin
               state_nxt = ST_ALLRED;
               tmr_load  = 1'b1;
               tmr_val   = CNT_W'(ALLRED_TIME - 1);
            end
         end
         ST_ALLRED: begin
            if (tmr_done) begin
`ifdef PED_SIG_EN
               if (ped_pend) begin
                  state_nxt = ST_PED;
                  ped_clr   = 1'b1;
                  tmr_load  = 1'b1;
                  tmr_val   = CNT_W'(WALK_TIME - 1);
               end else begin
                  state_nxt  = ST_GREEN;
                  active_nxt = next_appr;
                  tmr_load   = 1'b1;
               end
`else
               state_nxt  = ST_GREEN;
               active_nxt = next_appr;
               tmr_load   = 1'b1;
`endif
            end
         end
`ifdef PED_SIG_EN
         ST_PED: begin
            if (tmr_done) begin
               state_nxt  = ST_GREEN;
               active_nxt = next_appr;
               tmr_load   = 1'b1;
            end
         end
`endif
         default: begin
            state_nxt  = ST_GREEN;
            active_nxt = 3'd0;
            tmr_load   = 1'b1;
         end
      endcase
   end

   // light pattern for the upcoming cycle, registered below
   always_comb begin
      sig_nxt = '0;
      for (int i = 0; i < NUM_APPR; i++) begin
         if (state_nxt == ST_GREEN && active_nxt == 3'(i))
            sig_nxt[2*i +: 2] = LT_GREEN;
         else if (state_nxt == ST_YELLOW && active_nxt == 3'(i))
            sig_nxt[2*i +: 2] = LT_YELLOW;
         else
            sig_nxt[2*i +: 2] = LT_RED;
      end
   end

   // controller state and registered outputs
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state     <= ST_GREEN;
         active    <= 3'd0;
         next_appr <= 3'd0;
         sig       <= SIG_RST;
      end else begin
         state     <= state_nxt;
         active    <= active_nxt;
         next_appr <= next_appr_nxt;
         sig       <= sig_nxt;
      end
   end

`ifdef PED_SIG_EN
   // pedestrian request latch and walk indication
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         ped_pend <= 1'b0;
         walk     <= 1'b0;
      end else begin
         if (ped_clr)
            ped_pend <= 1'b0;
         else if (ped_req)
            ped_pend <= 1'b1;
         walk <= (state_nxt == ST_PED);
      end
   end
`endif

endmodule

// File: tb/tb_multi_sig_control.sv
// Bench for multi_sig_control (NUM_APPR=4, default timings) against a
// cycle-age reference model of the signal rules.
module tb_multi_sig_control;

   localparam int N     = 4;
   localparam int MIN_G = 4;
   localparam int MAX_G = 10;
   localparam int YEL   = 3;
   localparam int AR    = 2;

   localparam int PH_GO   = 0;
   localparam int PH_WARN = 1;
   localparam int PH_CLR  = 2;

   logic           clock   = 1'b0;
   logic           clear   = 1'b0;
   logic [N-1:0]   car_req = '0;
   logic [2*N-1:0] sig;
   logic [2:0]     active;
`ifdef PED_SIG_EN
   logic           ped_req = 1'b0;
   logic           walk;
`endif

   int checks   = 0;
   int failures = 0;

   int m_phase, m_age, m_act, m_next;

   always #5 clock = ~clock;

   multi_sig_control dut (
      .clock   (clock),
      .clear   (clear),
      .car_req (car_req),
`ifdef PED_SIG_EN
      .ped_req (ped_req),
      .walk    (walk),
`endif
      .sig     (sig),
      .active  (active)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int rr(input int act, input logic [N-1:0] r);
      for (int k = 1; k < N; k++) begin
         int idx;
         idx = (act + k) % N;
         if (r[idx]) return idx;
      end
      return 0;
   endfunction

   function automatic logic [2*N-1:0] exp_sig();
      logic [2*N-1:0] s;
      s = '0;
      if (m_phase == PH_GO)        s[2*m_act +: 2] = 2'd2;
      else if (m_phase == PH_WARN) s[2*m_act +: 2] = 2'd1;
      return s;
   endfunction

   task automatic model_reset();
      m_phase = PH_GO;
      m_age   = 0;
      m_act   = 0;
      m_next  = 0;
   endtask

   // m_age = cycles completed in the current phase, including the one ending now
   task automatic model_step(input logic [N-1:0] r);
      logic [N-1:0] others;
      bit go;
      others        = r;
      others[m_act] = 1'b0;
      m_age++;
      if (m_phase == PH_GO) begin
         if (m_age >= MIN_G) begin
            if (m_act == 0) go = (others != 0);
            else            go = !r[m_act] || (m_age >= MAX_G && others != 0);
            if (go) begin
               m_phase = PH_WARN;
               m_next  = rr(m_act, r);
               m_age   = 0;
            end
         end
      end else if (m_phase == PH_WARN) begin
         if (m_age >= YEL) begin
            m_phase = PH_CLR;
            m_age   = 0;
         end
      end else begin
         if (m_age >= AR) begin
            m_phase = PH_GO;
            m_act   = m_next;
            m_age   = 0;
         end
      end
   endtask

   task automatic tick();
      @(posedge clock);
      model_step(car_req);
      @(negedge clock);
      chk("sig", sig, exp_sig());
      chk("active", active, m_act);
`ifdef PED_SIG_EN
      chk("walk", walk, 0);
`endif
   endtask

   task automatic do_reset();
      @(negedge clock);
      clear = 1'b0;
      @(negedge clock);
      chk("rst_sig", sig, 8'h02);
      chk("rst_act", active, 0);
      clear = 1'b1;
      model_reset();
   endtask

   task automatic wait_sig(input logic [2*N-1:0] target, input int budget, input string tag);
      int n;
      n = 0;
      while (sig !== target && n < budget) begin
         tick();
         n++;
      end
      chk(tag, sig, target);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      model_reset();
      repeat (2) @(negedge clock);
      chk("rst_sig", sig, 8'h02);
      chk("rst_act", active, 0);
      clear = 1'b1;

      // no requests: main road stays green
      repeat (100) begin
         tick();
         chk("idle_sig", sig, 8'h02);
      end

      // approach 2 requesting from reset, then dropping
      do_reset();
      car_req = 4'b0100;
      for (int t = 1; t <= 14; t++) begin
         tick();
         if (t == 3) chk("hold_main", sig, 8'h02);
         if (t == 4) chk("first_yel", sig, 8'h01);
         if (t == 6) chk("last_yel", sig, 8'h01);
         if (t == 7) chk("allred", sig, 8'h00);
         if (t == 9) begin
            chk("green2", sig, 8'h20);
            chk("act2", active, 2);
         end
      end
      car_req = 4'b0000;
      for (int t = 15; t <= 20; t++) begin
         tick();
         if (t == 15) chk("yel2", sig, 8'h10);
         if (t == 17) chk("yel2_end", sig, 8'h10);
         if (t == 18) chk("allred2", sig, 8'h00);
         if (t == 20) begin
            chk("back0", sig, 8'h02);
            chk("back0_act", active, 0);
         end
      end

      // approaches 1 and 3 together: 1 first, then 3, then main
      car_req = 4'b1010;
      wait_sig(8'h08, 40, "serve1");
      car_req = 4'b1000;
      wait_sig(8'h80, 40, "serve3");
      chk("serve3_act", active, 3);
      car_req = 4'b0000;
      wait_sig(8'h02, 40, "serve_main");
      chk("serve_main_act", active, 0);

      // approach 1 held with competition: forced out at max green
      car_req = 4'b0010;
      wait_sig(8'h08, 40, "a1_green");
      n = 1;
      tick();
      car_req = 4'b0110;
      while (sig === 8'h08 && n < 40) begin
         n++;
         tick();
      end
      chk("a1_len", n, 10);
      chk("a1_yel", sig, 8'h04);
      car_req = 4'b0000;
      wait_sig(8'h02, 40, "a1_done");

      // asynchronous clear during yellow restarts a full minimum green
      car_req = 4'b0100;
      wait_sig(8'h01, 40, "yel_pre");
      #2 clear = 1'b0;
      #1;
      chk("async_sig", sig, 8'h02);
      chk("async_act", active, 0);
      @(negedge clock);
      clear = 1'b1;
      model_reset();
      for (int t = 1; t <= 4; t++) begin
         tick();
         if (t == 3) chk("restart_hold", sig, 8'h02);
         if (t == 4) chk("restart_yel", sig, 8'h01);
      end

      // random request traffic against the model
      car_req = 4'b0000;
      repeat (800) begin
         if ($urandom_range(0, 3) == 0) car_req = N'($urandom_range(0, 15));
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
